lix_pipe_reg: RTL and testbench
===============================

// Module: lix_pipe_reg
// PURPOSE
//  Parametrised elastic register pipeline: DEPTH stages of W-bit enable registers, each with its
//  own valid bit and valid/ready backpressure. Bubbles collapse, and throughput is 1 word/cycle.
//  It adds three things to the single enable register: global stall (i_en), synchronous flush and
//  an occupancy count. It sits between lix datapath units wherever a retimed, stallable hop is needed.
// PARAMETERS
//  W      32  data width, >=1
//  DEPTH  2   number of register stages, >=1 (DEPTH=1 gives a one-entry buffer)
//  CNT_W  $clog2(DEPTH+1)  width of o_cnt (derived, do not override)
// PORTS
//  clk_i    in   1      clock; all state updates on posedge
//  rst_ni   in   1      asynchronous, active-low reset
//  i_vld    in   1      upstream word valid
//  o_rdy    out  1      pipeline accepts i_x this cycle
//  i_x      in   W      upstream data
//  o_vld    out  1      output word valid
//  i_rdy    in   1      downstream accepts o_z this cycle
//  o_z      out  W      output data (= last stage register)
//  i_en     in   1      global enable; 0 freezes all state
//  i_flush  in   1      synchronous flush of all valid bits
//  o_cnt    out  CNT_W  number of valid stages (0..DEPTH)
// BEHAVIOUR
//  - Stage state: v[k], d[k], k=0..DEPTH-1. Stage 0 is the input side; stage DEPTH-1 drives o_vld/o_z.
//  - Reset (rst_ni=0, async): all v[k]=0 and all d[k]=0. So o_vld=0, o_z=0, o_cnt=0, and o_rdy=1 once i_en=1.
//  - Ready chain (combinational): r[DEPTH]=i_rdy, r[k]=~v[k] | r[k+1]. o_rdy = r[0] & i_en & ~i_flush.
//  - o_vld = v[DEPTH-1] & i_en & ~i_flush. Output transfer = o_vld & i_rdy.
//    Input transfer = i_vld & o_rdy.
//  - Stage k loads when i_en & ~i_flush & r[k]:
//    d[k] <= src, v[k] <= src_vld.
//    For k=0, src is i_x and src_vld is i_vld. For k>0, src is d[k-1] and src_vld is v[k-1].
//    d[k] is written only when src_vld=1; a bubble moving in leaves d[k] unchanged (saves power).
//  - Latency: an empty pipe with i_rdy=1 presents a word accepted in cycle t at o_z/o_vld in
//    cycle t+DEPTH. Throughput is 1 word/cycle when i_vld=i_rdy=1.
//  - Backpressure: i_rdy=0 with v[DEPTH-1]=1 holds the output stable. Upstream stages keep filling
//    into bubbles. o_rdy=0 only when all DEPTH stages are valid and i_rdy=0.
//  - Full (o_cnt=DEPTH) with i_rdy=1 and i_vld=1: simultaneous in/out, all stages shift, o_cnt stays DEPTH.
//  - Empty: o_vld=0, o_z holds the last delivered word (not cleared).
//  - i_en=0: no register changes, and o_rdy=0 and o_vld=0, so no handshake completes.
//    o_z and o_cnt still reflect held state.
//  - i_flush=1 (with i_en don't-care): next edge clears all v[k]. d[k] is untouched.
//    In the flush cycle o_rdy=0 and o_vld=0, so no word is accepted or lost mid-handshake.
//    Flush has priority over i_en and over transfers.
//  - o_cnt = popcount(v), registered-state derived (combinational from v); it changes only on clock edges.
//  - Reset asserted mid-stream: all in-flight words are dropped immediately (async). The first
//    edge after rst_ni deassertion behaves as an empty pipe.
//  - Ready path is combinational across DEPTH stages. Timing of the i_rdy->o_rdy path is the
//    user's responsibility for large DEPTH.
// STRUCTURE
//  - lix_pkg: function lix_clog2(n) for CNT_W, and localparam LIX_RST_DATA = '0 shared by lix register blocks.
//  - Sub-module lix_pipe_stage #(W): one valid+data stage with inputs load, src_vld, src_x and
//    outputs v, d. Same async reset. Instantiated DEPTH times in a generate loop.
//  - Top: ready chain, gating by i_en/i_flush, popcount for o_cnt.
// TESTING
//  1. Reset: rst_ni=0 for 3 cycles -> o_vld=0, o_z=0, o_cnt=0. Release with i_en=1 -> o_rdy=1.
//  2. Latency (DEPTH=2): one word 0xA5A5_0001 at t with i_rdy=1 -> o_vld=1 and o_z=0xA5A5_0001
//     at t+2 only, o_cnt=1 at t+1 and t+2.
//  3. Stream/backpressure: send 0..9 with i_rdy toggling 1,0,0,1 -> output order 0..9 exact,
//     no drop/duplicate. With i_rdy=0 o_rdy falls after 2 accepts and o_cnt=2.
//  4. Full + simultaneous: fill to o_cnt=2, then i_vld=i_rdy=1 for 5 cycles -> 5 in, 5 out,
//     o_cnt stays 2, o_rdy stays 1.
//  5. Stall: i_en=0 for 4 cycles mid-stream with i_vld=i_rdy=1 -> o_rdy=0, o_vld=0,
//     o_cnt/o_z frozen. Resume -> stream continues in order.
//  6. Flush + reset: o_cnt=2, pulse i_flush with i_vld=1 -> that word is not accepted, next cycle
//     o_cnt=0, o_vld=0. Async rst_ni pulse between edges mid-stream -> o_vld=0 immediately.

Source files
------------

// File: rtl/lix_pkg.sv
// Shared definitions for lix register blocks: reset data value and the
// elaboration-time log2 helper used to size occupancy counters.
package lix_pkg;

   localparam bit LIX_RST_DATA = 1'b0;

   function automatic int lix_clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < n) begin
            r = r + 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/lix_pipe_stage.sv
// One valid+data stage of the lix elastic pipeline.
// Data is written only when a valid word arrives.
module lix_pipe_stage
   import lix_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load,
   input  logic         src_vld,
   input  logic [W-1:0] src_x,
   output logic         v,
   output logic [W-1:0] d
);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         v <= 1'b0;
         d <= {W{LIX_RST_DATA}};
      end else if (load) begin
         v <= src_vld;
         if (src_vld) begin
            d <= src_x;
         end
      end
   end

endmodule

// File: rtl/lix_pipe_reg.sv
// Elastic DEPTH-stage register pipeline with bubble collapse,
// global stall, synchronous flush and occupancy count.
module lix_pipe_reg
   import lix_pkg::*;
#(
   parameter int W     = 32,
   parameter int DEPTH = 2,
   parameter int CNT_W = lix_clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             i_vld,
   output logic             o_rdy,
   input  logic [W-1:0]     i_x,
   output logic             o_vld,
   input  logic             i_rdy,
   output logic [W-1:0]     o_z,
   input  logic             i_en,
   input  logic             i_flush,
   output logic [CNT_W-1:0] o_cnt
);

   logic [DEPTH-1:0]        v;
   logic [DEPTH-1:0][W-1:0] d;
   logic [DEPTH:0]          r;
   logic                    go;
   logic [CNT_W-1:0]        cnt;

   assign go       = i_en & ~i_flush;
   assign r[DEPTH] = i_rdy;

   // Flush reuses the load path with a forced bubble, so data stays put.
   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic         load;
      logic         src_vld;
      logic [W-1:0] src_x;

      assign r[k] = ~v[k] | r[k+1];
      assign load = i_flush | (i_en & r[k]);

      if (k == 0) begin : g_head
         assign src_vld = i_vld & ~i_flush;
         assign src_x   = i_x;
      end else begin : g_body
         assign src_vld = v[k-1] & ~i_flush;
         assign src_x   = d[k-1];
      end

      lix_pipe_stage #(
         .W(W)
      ) u_stage (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .load    (load),
         .src_vld (src_vld),
         .src_x   (src_x),
         .v       (v[k]),
         .d       (d[k])
      );
   end

   always_comb begin
      cnt = '0;
      for (int k = 0; k < DEPTH; k++) begin
         cnt = cnt + CNT_W'(v[k]);
      end
   end

   assign o_rdy = r[0] & go;
   assign o_vld = v[DEPTH-1] & go;
   assign o_z   = d[DEPTH-1];
   assign o_cnt = cnt;

endmodule

// File: tb/tb_lix_pipe_reg.sv
// Scoreboard bench for lix_pipe_reg (W=32, DEPTH=2): accepted words are
// queued and must leave in order; o_cnt must track the queue depth.
module tb_lix_pipe_reg;

   localparam int W     = 32;
   localparam int DEPTH = 2;
   localparam int CNT_W = 2;

   logic             clk_i;
   logic             rst_ni;
   logic             i_vld;
   logic             o_rdy;
   logic [W-1:0]     i_x;
   logic             o_vld;
   logic             i_rdy;
   logic [W-1:0]     o_z;
   logic             i_en;
   logic             i_flush;
   logic [CNT_W-1:0] o_cnt;

   logic [W-1:0] q[$];
   int n_chk;
   int n_fail;
   int n_in;
   int n_out;

   lix_pipe_reg #(
      .W     (W),
      .DEPTH (DEPTH)
   ) dut (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .i_vld   (i_vld),
      .o_rdy   (o_rdy),
      .i_x     (i_x),
      .o_vld   (o_vld),
      .i_rdy   (i_rdy),
      .o_z     (o_z),
      .i_en    (i_en),
      .i_flush (i_flush),
      .o_cnt   (o_cnt)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Sample just after the inputs settle, then advance to the next negedge.
   task automatic tick();
      logic [W-1:0] e;
      #1;
      chk("cnt", 64'(o_cnt), 64'(q.size()));
      if (o_vld && i_rdy) begin
         chk("sb_nonempty", 64'(q.size() != 0), 64'd1);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("data", 64'(o_z), 64'(e));
         end
         n_out++;
      end
      if (i_vld && o_rdy) begin
         q.push_back(i_x);
         n_in++;
      end
      @(negedge clk_i);
   endtask

   task automatic drain();
      i_vld = 1'b0;
      i_rdy = 1'b1;
      for (int c = 0; c < 20 && q.size() > 0; c++) begin
         tick();
      end
      chk("drain", 64'(q.size()), 64'd0);
   endtask

   task automatic fill2(input logic [W-1:0] base);
      i_rdy = 1'b0;
      i_vld = 1'b1;
      for (int c = 0; c < 2; c++) begin
         i_x = base + W'(c);
         tick();
      end
      i_vld = 1'b0;
      #1;
      chk("fill_cnt", 64'(o_cnt), 64'd2);
      chk("fill_rdy", 64'(o_rdy), 64'd0);
   endtask

   logic [3:0] pat;
   int sent;
   int base_in;
   int base_out;
   int k;

   initial begin
      n_chk = 0; n_fail = 0; n_in = 0; n_out = 0;
      rst_ni = 1'b0; i_vld = 1'b0; i_x = '0; i_rdy = 1'b0;
      i_en = 1'b0; i_flush = 1'b0;
      pat = 4'b1001;

      // Reset
      repeat (3) @(negedge clk_i);
      chk("rst_vld", 64'(o_vld), 64'd0);
      chk("rst_z", 64'(o_z), 64'd0);
      chk("rst_cnt", 64'(o_cnt), 64'd0);
      rst_ni = 1'b1;
      i_en = 1'b1;
      #1;
      chk("rst_rdy", 64'(o_rdy), 64'd1);
      @(negedge clk_i);

      // Latency
      i_rdy = 1'b1;
      i_vld = 1'b1;
      i_x = 32'hA5A5_0001;
      tick();
      i_vld = 1'b0;
      #1;
      chk("lat1_vld", 64'(o_vld), 64'd0);
      chk("lat1_cnt", 64'(o_cnt), 64'd1);
      tick();
      #1;
      chk("lat2_vld", 64'(o_vld), 64'd1);
      chk("lat2_z", 64'(o_z), 64'hA5A5_0001);
      chk("lat2_cnt", 64'(o_cnt), 64'd1);
      tick();
      #1;
      chk("lat3_vld", 64'(o_vld), 64'd0);
      chk("lat3_z", 64'(o_z), 64'hA5A5_0001);

      // Stream 0..9 with toggling backpressure
      sent = 0;
      base_out = n_out;
      for (int c = 0; c < 200 && (n_out - base_out) < 10; c++) begin
         i_vld = (sent < 10);
         i_x = W'(sent);
         i_rdy = pat[c % 4];
         base_in = n_in;
         tick();
         if (n_in != base_in) sent++;
      end
      chk("stream_out", 64'(n_out - base_out), 64'd10);
      chk("stream_q", 64'(q.size()), 64'd0);

      // Backpressure fill then full + simultaneous
      fill2(32'd100);
      base_in = n_in;
      base_out = n_out;
      i_vld = 1'b1;
      i_rdy = 1'b1;
      for (int c = 0; c < 5; c++) begin
         i_x = 32'd200 + W'(c);
         #1;
         chk("full_rdy", 64'(o_rdy), 64'd1);
         chk("full_cnt", 64'(o_cnt), 64'd2);
         tick();
      end
      chk("full_in", 64'(n_in - base_in), 64'd5);
      chk("full_out", 64'(n_out - base_out), 64'd5);
      drain();

      // Stall mid-stream
      i_vld = 1'b1;
      i_rdy = 1'b1;
      k = 300;
      for (int c = 0; c < 3; c++) begin
         i_x = W'(k); k++;
         tick();
      end
      i_en = 1'b0;
      for (int c = 0; c < 4; c++) begin
         i_x = W'(k);
         #1;
         chk("stall_rdy", 64'(o_rdy), 64'd0);
         chk("stall_vld", 64'(o_vld), 64'd0);
         if (q.size() != 0) chk("stall_z", 64'(o_z), 64'(q[0]));
         tick();
      end
      i_en = 1'b1;
      for (int c = 0; c < 3; c++) begin
         i_x = W'(k); k++;
         tick();
      end
      drain();

      // Flush
      fill2(32'd400);
      i_flush = 1'b1;
      i_vld = 1'b1;
      i_rdy = 1'b1;
      i_x = 32'hDEAD_BEEF;
      #1;
      chk("flush_rdy", 64'(o_rdy), 64'd0);
      chk("flush_vld", 64'(o_vld), 64'd0);
      tick();
      q.delete();
      i_flush = 1'b0;
      i_vld = 1'b0;
      #1;
      chk("flush_cnt", 64'(o_cnt), 64'd0);
      chk("flush_ovld", 64'(o_vld), 64'd0);
      chk("flush_z", 64'(o_z), 64'd400);
      tick();

      // Async reset mid-stream
      i_vld = 1'b1;
      i_rdy = 1'b0;
      for (int c = 0; c < 2; c++) begin
         i_x = 32'd500 + W'(c);
         tick();
      end
      i_vld = 1'b0;
      #2;
      rst_ni = 1'b0;
      #1;
      chk("arst_vld", 64'(o_vld), 64'd0);
      chk("arst_cnt", 64'(o_cnt), 64'd0);
      chk("arst_z", 64'(o_z), 64'd0);
      q.delete();
      #1;
      rst_ni = 1'b1;
      @(negedge clk_i);
      i_vld = 1'b1;
      i_rdy = 1'b1;
      i_x = 32'h0000_0600;
      tick();
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
